reg_file_wb_sink: RTL and testbench
===================================

// Module: reg_file_wb_sink
// PURPOSE
//  Integer register file (x0..x31) that consumes the writeback-stage write port (RegWriteW/RD_W/ResultW).
//  Serves the two decode-stage read ports, with same-cycle write-to-read bypass.
//  Keeps a pending-write scoreboard: decode marks a destination busy at issue, writeback clears it.
//  Raises a stall to the hazard logic while a decode source is busy.
// PARAMETERS
//  XLEN      32   data width of each register
//  NREGS     32   number of architectural registers (address width = 5)
//  CNT_W     32   width of the committed-write counter
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-low
//  RegWriteW    in   1      writeback write enable
//  RD_W         in   5      writeback destination register
//  ResultW      in   XLEN   writeback data
//  rs1_D        in   5      decode source 1 address
//  rs2_D        in   5      decode source 2 address
//  rs1_use_D    in   1      decode instruction actually reads rs1
//  rs2_use_D    in   1      decode instruction actually reads rs2
//  issue_valid  in   1      instruction leaving decode this cycle (not stalled/flushed)
//  issue_rd     in   5      destination of the issuing instruction
//  issue_busy   in   1      issuing instruction must mark issue_rd pending (e.g. load)
//  RD1_D        out  XLEN   read data port 1 (combinational)
//  RD2_D        out  XLEN   read data port 2 (combinational)
//  stall_D      out  1      decode must hold: a used source is pending
//  busy_vec     out  NREGS  scoreboard state; bit 0 is always 0
//  wb_count     out  CNT_W  number of committed register writes
// BEHAVIOUR
//  Reset (rst=0, async): all registers=0, busy_vec=0, wb_count=0; RD1_D/RD2_D=0, stall_D=0 while in reset.
//  Write: at posedge clk, if RegWriteW && RD_W!=0 then regs[RD_W]<=ResultW and wb_count<=wb_count+1.
//  wb_count wraps from 2^CNT_W-1 to 0. Writes to x0 are dropped and not counted.
//  Read: RDn_D = 0 if rsn_D==0.
//  Otherwise, if RegWriteW && RD_W==rsn_D, RDn_D = ResultW (bypass: write-before-read).
//  Otherwise RDn_D = regs[rsn_D]. No read latency.
//  Scoreboard, evaluated at posedge clk:
//   - clr: RegWriteW && RD_W!=0 clears busy[RD_W].
//   - set: issue_valid && issue_busy && issue_rd!=0 sets busy[issue_rd].
//   - set and clear of the same register in one cycle: set wins (newer producer outstanding).
//   - A clear of a register that is not busy is harmless; busy[0] is never set.
//  stall_D (combinational), OR over n=1,2 of:
//   rsn_use_D && rsn_D!=0 && busy[rsn_D] && !(RegWriteW && RD_W==rsn_D).
//   The in-flight writeback releases the stall in the same cycle; the bypass supplies the data.
//  issue_valid is asserted only when stall_D=0; the block does not check this.
//  Reset mid-operation: all state clears immediately, with no partial write committed.
//  Single producer per register: a second set on an already-busy register keeps it busy;
//   the first matching writeback clears it.
// TESTING
//  1. Reset -> RD1_D=RD2_D=0, busy_vec=0, wb_count=0; release rst, read x5 -> 0.
//  2. RegWriteW=1, RD_W=5, ResultW=32'hDEADBEEF, rs1_D=5 in the same cycle -> RD1_D=DEADBEEF before the edge;
//     after the edge regs[5]=DEADBEEF and wb_count=1.
//  3. RegWriteW=1, RD_W=0, ResultW=32'h1234 -> x0 still reads 0, wb_count unchanged.
//  4. Issue load to x7 (issue_busy=1) -> busy_vec[7]=1; next cycle rs2_D=7, rs2_use_D=1 -> stall_D=1;
//     with rs2_use_D=0 -> stall_D=0; writeback RD_W=7, ResultW=42 -> stall_D=0 same cycle, RD2_D=42,
//     busy_vec[7]=0 after the edge.
//  5. Same cycle: issue_rd=9 with issue_busy=1, and RegWriteW with RD_W=9 -> busy_vec[9]=1 after the edge.
//  6. Preload wb_count=32'hFFFFFFFF, then one valid write -> wb_count=0.
//     Assert rst mid-stream with busy bits set -> busy_vec=0, regs=0 immediately.

Source files
------------

// File: rtl/reg_file_wb_sink.sv
// Integer register file x0..x31 fed by the writeback port, with two bypassed
// combinational read ports, a pending-write scoreboard and a decode stall.
module reg_file_wb_sink #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteW,
    input  logic [4:0]       RD_W,
    input  logic [XLEN-1:0]  ResultW,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic             rs1_use_D,
    input  logic             rs2_use_D,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic             issue_busy,
    output logic [XLEN-1:0]  RD1_D,
    output logic [XLEN-1:0]  RD2_D,
    output logic             stall_D,
    output logic [NREGS-1:0] busy_vec,
    output logic [CNT_W-1:0] wb_count
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_n;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_en;
    logic             set_en;
    logic             byp1;
    logic             byp2;
    logic             stall1;
    logic             stall2;

    // issue_valid is a single-cycle strobe raised by decode only while stall_D
    // is low; the block trusts that and does not re-check it.
    assign wr_en  = RegWriteW && (RD_W != 5'd0);
    assign set_en = issue_valid && issue_busy && (issue_rd != 5'd0);
    assign byp1   = RegWriteW && (RD_W == rs1_D);
    assign byp2   = RegWriteW && (RD_W == rs2_D);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[RD_W] <= ResultW;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (wr_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Set is applied after clear so a newly issued producer stays outstanding.
    always_comb begin
        busy_n = busy_q;
        if (wr_en) begin
            busy_n[RD_W] = 1'b0;
        end
        if (set_en) begin
            busy_n[issue_rd] = 1'b1;
        end
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_n;
        end
    end

    always_comb begin
        RD1_D = '0;
        RD2_D = '0;
        if (rst) begin
            if (rs1_D != 5'd0) begin
                RD1_D = byp1 ? ResultW : regs[rs1_D];
            end
            if (rs2_D != 5'd0) begin
                RD2_D = byp2 ? ResultW : regs[rs2_D];
            end
        end
    end

    // A writeback landing this cycle releases the stall; the bypass supplies its data.
    assign stall1  = rs1_use_D && (rs1_D != 5'd0) && busy_q[rs1_D] && !byp1;
    assign stall2  = rs2_use_D && (rs2_D != 5'd0) && busy_q[rs2_D] && !byp2;
    assign stall_D = rst && (stall1 || stall2);

    assign busy_vec = busy_q;
    assign wb_count = cnt_q;

endmodule

// File: tb/tb_reg_file_wb_sink.sv
// Bench for reg_file_wb_sink: directed scenarios with literal expectations plus
// random traffic compared every cycle against an array-based model.
module tb_reg_file_wb_sink;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int CNT_W = 8;
    localparam int W     = 2 * XLEN + 1 + NREGS + CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             RegWriteW;
    logic [4:0]       RD_W;
    logic [XLEN-1:0]  ResultW;
    logic [4:0]       rs1_D;
    logic [4:0]       rs2_D;
    logic             rs1_use_D;
    logic             rs2_use_D;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic             issue_busy;
    logic [XLEN-1:0]  RD1_D;
    logic [XLEN-1:0]  RD2_D;
    logic             stall_D;
    logic [NREGS-1:0] busy_vec;
    logic [CNT_W-1:0] wb_count;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]     exp_q[$];
    logic [XLEN-1:0]  m_regs [NREGS];
    logic             m_busy [NREGS];
    logic [CNT_W-1:0] m_cnt;

    reg_file_wb_sink #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .RegWriteW(RegWriteW), .RD_W(RD_W), .ResultW(ResultW),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_use_D(rs1_use_D), .rs2_use_D(rs2_use_D),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_busy(issue_busy),
        .RD1_D(RD1_D), .RD2_D(RD2_D), .stall_D(stall_D),
        .busy_vec(busy_vec), .wb_count(wb_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_cnt = '0;
    endtask

    function automatic logic [XLEN-1:0] m_read(input logic [4:0] a);
        if (!rst || a == 5'd0) return '0;
        if (RegWriteW && RD_W == a) return ResultW;
        return m_regs[a];
    endfunction

    function automatic logic m_src_stall(input logic [4:0] a, input logic use_it);
        return rst && use_it && a != 5'd0 && m_busy[a] && !(RegWriteW && RD_W == a);
    endfunction

    function automatic logic [NREGS-1:0] m_busy_vec();
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
        v[0] = 1'b0;
        return v;
    endfunction

    // State update at a rising edge from the inputs that were live across it.
    task automatic model_commit();
        if (!rst) begin
            model_clear();
        end else begin
            if (RegWriteW && RD_W != 5'd0) begin
                m_regs[RD_W] = ResultW;
                m_cnt        = m_cnt + 1'b1;
                m_busy[RD_W] = 1'b0;
            end
            if (issue_valid && issue_busy && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic we, input logic [4:0] rd, input logic [XLEN-1:0] res,
                         input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                         input logic iv, input logic [4:0] ird, input logic ib);
        logic stl;
        RegWriteW = we;  RD_W = rd;  ResultW = res;
        rs1_D = r1;  rs2_D = r2;  rs1_use_D = u1;  rs2_use_D = u2;
        issue_rd = ird;  issue_busy = ib;
        if (!rst) model_clear();
        stl = m_src_stall(r1, u1) || m_src_stall(r2, u2);
        issue_valid = iv && !stl;
        exp_q.push_back({m_read(r1), m_read(r2), stl, m_busy_vec(), m_cnt});
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b0, 5'd0, '0, r1, r2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd1",      RD1_D,                  e[W-1 -: XLEN]);
            chk("rd2",      RD2_D,                  e[W-1-XLEN -: XLEN]);
            chk("stall",    XLEN'(stall_D),         XLEN'(e[NREGS+CNT_W]));
            chk("busy_vec", XLEN'(busy_vec),        XLEN'(e[NREGS+CNT_W-1 -: NREGS]));
            chk("wb_count", XLEN'(wb_count),        XLEN'(e[CNT_W-1:0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        model_clear();
        #1;
        // Reset state
        idle(5'd5, 5'd0);
        mid();
        chk("reset_rd1", RD1_D, 32'h0);
        chk("reset_busy", XLEN'(busy_vec), 32'h0);
        chk("reset_cnt", XLEN'(wb_count), 32'h0);
        cycle();
        rst = 1'b1;
        idle(5'd5, 5'd5);
        mid();
        chk("x5_after_reset", RD1_D, 32'h0);
        cycle();

        // Write with same-cycle bypass
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        mid();
        chk("bypass_rd1", RD1_D, 32'hDEADBEEF);
        cycle();
        idle(5'd5, 5'd0);
        mid();
        chk("x5_stored", RD1_D, 32'hDEADBEEF);
        chk("cnt_one", XLEN'(wb_count), 32'h1);
        cycle();

        // Write to x0 is dropped and not counted
        drive(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        mid();
        chk("x0_bypass_blocked", RD1_D, 32'h0);
        cycle();
        idle(5'd0, 5'd0);
        mid();
        chk("x0_still_zero", RD2_D, 32'h0);
        chk("cnt_unchanged", XLEN'(wb_count), 32'h1);
        cycle();

        // Load to x7: busy, stall, release by writeback
        drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1);
        cycle();
        drive(1'b0, 5'd0, '0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        mid();
        chk("busy7_set", XLEN'(busy_vec[7]), 32'h1);
        chk("stall_on_x7", XLEN'(stall_D), 32'h1);
        cycle();
        drive(1'b0, 5'd0, '0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        mid();
        chk("no_stall_unused", XLEN'(stall_D), 32'h0);
        cycle();
        drive(1'b1, 5'd7, 32'd42, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        mid();
        chk("wb_releases_stall", XLEN'(stall_D), 32'h0);
        chk("wb_bypass_rd2", RD2_D, 32'd42);
        cycle();
        idle(5'd0, 5'd7);
        mid();
        chk("busy7_cleared", XLEN'(busy_vec[7]), 32'h0);
        cycle();

        // Set and clear of x9 in the same cycle: set wins
        drive(1'b1, 5'd9, 32'h99, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
        cycle();
        idle(5'd9, 5'd0);
        mid();
        chk("busy9_set_wins", XLEN'(busy_vec[9]), 32'h1);
        chk("cnt_three", XLEN'(wb_count), 32'h3);
        cycle();

        // Drive the counter to all-ones, then wrap
        for (int i = 0; i < 252; i++) begin
            drive(1'b1, 5'(1 + i % 31), $urandom, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
            cycle();
        end
        drive(1'b1, 5'd2, 32'h2222, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        mid();
        chk("cnt_all_ones", XLEN'(wb_count), 32'hFF);
        cycle();
        idle(5'd2, 5'd0);
        mid();
        chk("cnt_wrapped", XLEN'(wb_count), 32'h0);
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            cycle();
        end

        // Reset mid-operation with busy bits set and a write pending
        drive(1'b1, 5'd3, 32'h00A5A5A5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1);
        cycle();
        drive(1'b1, 5'd6, 32'h77, 5'd3, 5'd6, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        mid();
        chk("x3_before_reset", RD1_D, 32'h00A5A5A5);
        chk("busy4_before_reset", XLEN'(busy_vec[4]), 32'h1);
        rst = 1'b0;
        model_clear();
        #1;
        chk("async_busy_clear", XLEN'(busy_vec), 32'h0);
        chk("async_rd1_zero", RD1_D, 32'h0);
        chk("async_rd2_zero", RD2_D, 32'h0);
        chk("async_cnt_zero", XLEN'(wb_count), 32'h0);
        cycle();
        rst = 1'b1;
        idle(5'd3, 5'd6);
        mid();
        chk("x3_cleared", RD1_D, 32'h0);
        chk("x6_not_committed", RD2_D, 32'h0);
        cycle();
        idle(5'd0, 5'd0);
        cycle();
        mid();

        if (exp_q.size() != 0) chk("exp_q_drained", XLEN'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
